// File: rtl/ram_ctrl_if.sv
// Request/response handshake bundle between a client and ram_ctrl.
// The client side takes the master modport and ram_ctrl takes the slave modport.
interface ram_ctrl_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/ram_ctrl.sv
// Single-port synchronous RAM front-end: one access at a time, owns bus turnaround.
// Optional power-on zero fill of the non-reserved range when RAM_CTRL_INIT_EN is defined.
//
// state   | meaning
// INIT    | zero-filling 0 .. top of non-reserved range (RAM_CTRL_INIT_EN only)
// IDLE    | ready for a request
// WRITE   | cs/we strobed, controller drives mem_data
// RD1     | cs/oe strobed, RAM registers the addressed word
// RD2     | strobes held, RAM drives mem_data, sampled into resp_rdata
// RESP    | response held until resp_ready
module ram_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   ram_ctrl_if.slave             bus,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe,
   inout  wire  [DATA_WIDTH-1:0] mem_data
);

   typedef enum logic [2:0] {
`ifdef RAM_CTRL_INIT_EN
      S_INIT,
`endif
      S_IDLE,
      S_WRITE,
      S_RD1,
      S_RD2,
      S_RESP
   } state_t;

   state_t                state_q;
   state_t                state_nx;
   logic                  cs_nx;
   logic                  we_nx;
   logic                  oe_nx;
   logic                  accept;
   logic                  reserved;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

`ifdef RAM_CTRL_INIT_EN
   // Last non-reserved address: top nibble 1110, remaining bits all ones.
   localparam logic [ADDR_WIDTH-1:0] INIT_LAST = {4'hE, {(ADDR_WIDTH-4){1'b1}}};
   logic [ADDR_WIDTH-1:0] init_cnt;
`endif

   assign accept   = bus.req_valid && (state_q == S_IDLE);
   assign reserved = &bus.req_addr[ADDR_WIDTH-1:ADDR_WIDTH-4];

   always_comb begin
      state_nx = state_q;
      cs_nx    = 1'b0;
      we_nx    = 1'b0;
      oe_nx    = 1'b0;
      case (state_q)
`ifdef RAM_CTRL_INIT_EN
         S_INIT: begin
            cs_nx = 1'b1;
            we_nx = 1'b1;
            if (init_cnt == INIT_LAST) state_nx = S_IDLE;
         end
`endif
         S_IDLE: begin
            if (accept) begin
               if (reserved) begin
                  state_nx = S_RESP;
               end else if (bus.req_we) begin
                  state_nx = S_WRITE;
                  cs_nx    = 1'b1;
                  we_nx    = 1'b1;
               end else begin
                  state_nx = S_RD1;
                  cs_nx    = 1'b1;
                  oe_nx    = 1'b1;
               end
            end
         end
         S_WRITE: state_nx = S_RESP;
         S_RD1: begin
            state_nx = S_RD2;
            cs_nx    = 1'b1;
            oe_nx    = 1'b1;
         end
         S_RD2:   state_nx = S_RESP;
         S_RESP:  if (bus.resp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
`ifdef RAM_CTRL_INIT_EN
         state_q  <= S_INIT;
         init_cnt <= '0;
`else
         state_q  <= S_IDLE;
`endif
         mem_cs      <= 1'b0;
         mem_we      <= 1'b0;
         mem_oe      <= 1'b0;
         mem_address <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_nx;
         mem_cs  <= cs_nx;
         mem_we  <= we_nx;
         mem_oe  <= oe_nx;
         if (accept) begin
            mem_address <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            rdata_q     <= '0;
            err_q       <= reserved;
         end
`ifdef RAM_CTRL_INIT_EN
         // wdata_q is still zero from reset while filling.
         if (state_q == S_INIT) begin
            mem_address <= init_cnt;
            init_cnt    <= init_cnt + 1'b1;
         end
`endif
         if (state_q == S_RD2) rdata_q <= mem_data;
      end
   end

   // Bus driven from the same register as mem_we, so it can never overlap RAM output.
   assign mem_data = mem_we ? wdata_q : {DATA_WIDTH{1'bz}};

   assign bus.req_ready  = (state_q == S_IDLE);
   assign bus.resp_valid = (state_q == S_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

`ifdef RAM_CTRL_INIT_EN
   assign init_done = (state_q != S_INIT);
`else
   assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl with a behavioural single-port RAM on the shared bus.
module tb_ram_ctrl;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        init_done;
   logic [7:0]  mem_address;
   logic        mem_cs, mem_we, mem_oe;
   wire  [63:0] mem_data;

   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];
   logic cs_seen = 1'b0;

   ram_ctrl_if #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) bus ();

   ram_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .bus(bus), .init_done(init_done),
      .mem_address(mem_address), .mem_cs(mem_cs), .mem_we(mem_we),
      .mem_oe(mem_oe), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   // RAM: write at edge, registered read, output drives while oe and not we
   logic [63:0] ram [0:255];
   logic [63:0] ram_q = 64'h0;
   wire         ram_drive = mem_cs && mem_oe && !mem_we;
   assign mem_data = ram_drive ? ram_q : 64'hz;
   always @(posedge clk) begin
      if (mem_cs && mem_we) ram[mem_address] <= mem_data;
      else if (mem_cs && mem_oe) ram_q <= ram[mem_address];
   end

`ifdef RAM_CTRL_INIT_EN
   localparam logic EXP_READY_RST = 1'b0;
   localparam logic EXP_DONE_RST  = 1'b0;
`else
   localparam logic EXP_READY_RST = 1'b1;
   localparam logic EXP_DONE_RST  = 1'b1;
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor / scoreboard
   always @(negedge clk) begin
      if (bus.resp_valid && bus.resp_ready) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got rdata=%h err=%b expected none",
                     bus.resp_rdata, bus.resp_err);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("resp_rdata", bus.resp_rdata, e.rdata);
            check("resp_err", 64'(bus.resp_err), 64'(e.err));
         end
      end
   end

   // Bus ownership monitor
   always @(negedge clk) begin
      if (mem_cs) begin
         cs_seen = 1'b1;
         check("bus_contention", 64'(mem_we && (ram_drive || mem_oe)), 64'd0);
      end
   end

   task automatic wait_init();
      int n = 0;
      while (!init_done && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("init_done_rise", 64'(init_done), 64'd1);
   endtask

   task automatic do_req(input logic we, input logic [7:0] addr, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input logic exp_err, input int exp_lat);
      int n = 0;
      int lat;
      exp_t e;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) check("req_ready_timeout", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.resp_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      if (bus.resp_ready) @(negedge clk);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = 8'h00;
      bus.req_wdata  = 64'h0;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 256; i++) ram[i] = 64'hDEAD_BEEF_0000_0000 | 64'(i);

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(bus.req_ready), 64'(EXP_READY_RST));
      check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("rst_resp_rdata", bus.resp_rdata, 64'd0);
      check("rst_resp_err", 64'(bus.resp_err), 64'd0);
      check("rst_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
      check("rst_mem_address", 64'(mem_address), 64'd0);
      check("rst_init_done", 64'(init_done), 64'(EXP_DONE_RST));
      reset = 1'b0;
      wait_init();

`ifdef RAM_CTRL_INIT_EN
      do_req(1'b0, 8'h00, 64'h0, 64'h0, 1'b0, 3);
      do_req(1'b0, 8'hEF, 64'h0, 64'h0, 1'b0, 3);
`endif

      // Basic write then read
      do_req(1'b1, 8'h10, 64'h0123456789ABCDEF, 64'h0, 1'b0, 2);
      do_req(1'b0, 8'h10, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3);

      // Reserved window: no RAM strobe
      cs_seen = 1'b0;
      do_req(1'b1, 8'hF3, 64'h1111_2222_3333_4444, 64'h0, 1'b1, 1);
      do_req(1'b0, 8'hF3, 64'h0, 64'h0, 1'b1, 1);
      check("err_no_cs", 64'(cs_seen), 64'd0);

      // Alternating traffic on 0x00/0x01
      do_req(1'b1, 8'h00, 64'hAAAA_5555_AAAA_5555, 64'h0, 1'b0, 2);
      do_req(1'b1, 8'h01, 64'h0F0F_F0F0_1234_5678, 64'h0, 1'b0, 2);
      do_req(1'b0, 8'h00, 64'h0, 64'hAAAA_5555_AAAA_5555, 1'b0, 3);
      do_req(1'b0, 8'h01, 64'h0, 64'h0F0F_F0F0_1234_5678, 1'b0, 3);
      do_req(1'b1, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 2);
      do_req(1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3);
      do_req(1'b0, 8'h01, 64'h0, 64'h0F0F_F0F0_1234_5678, 1'b0, 3);

      // Window boundaries
      do_req(1'b1, 8'hEF, 64'hCAFE_F00D_0000_00EF, 64'h0, 1'b0, 2);
      do_req(1'b0, 8'hEF, 64'h0, 64'hCAFE_F00D_0000_00EF, 1'b0, 3);
      do_req(1'b0, 8'hF0, 64'h0, 64'h0, 1'b1, 1);
      cs_seen = 1'b0;
      do_req(1'b1, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A, 64'h0, 1'b1, 1);
      check("err_ff_no_cs", 64'(cs_seen), 64'd0);

      // Response back-pressure
      bus.resp_ready = 1'b0;
      do_req(1'b0, 8'h10, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_valid", 64'(bus.resp_valid), 64'd1);
         check("stall_rdata", bus.resp_rdata, 64'h0123456789ABCDEF);
         check("stall_req_ready", 64'(bus.req_ready), 64'd0);
         check("stall_cs", 64'(mem_cs), 64'd0);
      end
      @(posedge clk);
      #1 bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_stall_req_ready", 64'(bus.req_ready), 64'd1);
      check("post_stall_valid", 64'(bus.resp_valid), 64'd0);

      // Reset while in RD2: read is dropped
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 8'h01;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rd2_oe", 64'(mem_oe), 64'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rstrd2_valid", 64'(bus.resp_valid), 64'd0);
      check("rstrd2_strobes", {61'd0, mem_cs, mem_we, mem_oe}, 64'd0);
      check("rstrd2_req_ready", 64'(bus.req_ready), 64'(EXP_READY_RST));
      begin
         int seen = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen++;
         end
         check("dropped_no_resp", 64'(seen), 64'd0);
      end
      wait_init();
`ifdef RAM_CTRL_INIT_EN
      do_req(1'b0, 8'h10, 64'h0, 64'h0, 1'b0, 3);
`else
      do_req(1'b0, 8'h10, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3);
`endif

      begin
         int n = 0;
         while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Request/response front-end for the single-port synchronous RAM (64-bit data, 8-bit address, shared tri-state data bus). Sits directly upstream of the RAM: accepts one read or write at a time over a valid/ready handshake and sequences the RAM's cs/we/oe strobes. It owns the bidirectional bus turnaround, returns registered read data, and rejects accesses to the reserved top window without touching the RAM.

## Interface
Parameters:
- DATA_WIDTH, 64, data word width
- ADDR_WIDTH, 8, address width; reserved window = address[ADDR_WIDTH-1:ADDR_WIDTH-4] all ones (0xF0–0xFF at default)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  request address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors
- resp_err  out  1  request hit reserved window
- init_done  out  1  controller initialised and serviceable
- mem_address  out  ADDR_WIDTH  RAM address
- mem_cs, mem_we, mem_oe  out  1 each  RAM chip select / write enable / output enable
- mem_data  inout  DATA_WIDTH  RAM data bus

## Operation
- States: INIT (macro only), IDLE, WRITE, RD1, RD2, RESP.
- IDLE: req_ready=1. Accept on req_valid&req_ready; latch we/addr/wdata.
  - Reserved address -> RESP, resp_err=1, resp_rdata=0; no RAM strobe.
  - Write -> WRITE; read -> RD1.
- WRITE: mem_cs=1, mem_we=1, mem_oe=0, mem_data driven with latched wdata; RAM writes at end of cycle -> RESP, resp_err=0, resp_rdata=0.
- RD1: mem_cs=1, mem_we=0, mem_oe=1; RAM registers data at end of cycle -> RD2.
- RD2: strobes held; mem_data sampled at end of cycle into resp_rdata -> RESP.
- RESP: resp_valid=1, resp_rdata/resp_err stable until resp_ready; on resp_valid&resp_ready -> IDLE.
- Bus ownership: mem_data driven only while mem_we=1 (same register), else high-Z. Controller and RAM never drive simultaneously.
- All strobes and mem_address are registered; no combinational path req_* -> mem_*.
- req_ready=0 in every state except IDLE; no accept in the cycle RESP retires.

## Timing
- Reset values: req_ready=0 (INIT) or 1 (IDLE), resp_valid=0, resp_rdata=0, resp_err=0, mem_cs=mem_we=mem_oe=0, mem_address=0, mem_data high-Z, init_done per Configuration.
- Acceptance cycle C. Error: resp_valid from C+1. Write: strobe C+1, resp_valid from C+2. Read: RD1 C+1, RD2 C+2, resp_valid from C+3.
- Max throughput with resp_ready=1: error 1 per 2 cycles, write 1 per 3, read 1 per 4.
- Reset mid-transaction: state -> INIT/IDLE next cycle, transaction dropped, no response. A reset asserted during WRITE does not cancel the RAM write already strobed that cycle (RAM has no reset).
- resp_ready held low: response held indefinitely, no further RAM activity.

## Configuration
- RAM_CTRL_INIT_EN defined: after reset enter INIT; write 0 to every non-reserved address 0 .. 2^ADDR_WIDTH-2^(ADDR_WIDTH-4)-1 (0x00–0xEF, 240 cycles), one per cycle, mem_cs=mem_we=1; req_ready=0, init_done=0 throughout; then IDLE with init_done=1. Reset during INIT restarts at address 0.
- Undefined: no INIT state; init_done tied 1; IDLE immediately after reset.

## Test plan
- Write 0x0123456789ABCDEF to 0x10, then read 0x10 -> write resp at C+2 (err=0, rdata=0); read resp at C+3 with rdata=0x0123456789ABCDEF.
- Write/read to 0xF3 -> resp_err=1, rdata=0 at C+1; mem_cs stays 0; subsequent read of 0xF3 also err.
- Read with resp_ready low 10 cycles -> resp_valid/rdata stable, req_ready=0, mem_cs=0 until handshake; then req_ready=1 next cycle.
- Reset in RD2 -> next cycle resp_valid=0, all strobes 0, req_ready per config; no response ever emitted for dropped read.
- Bus check on alternating write/read to 0x00/0x01 -> mem_data never X from contention; high-Z whenever mem_we=0 and RAM not driving.
- With RAM_CTRL_INIT_EN: pre-load junk, reset -> init_done rises after 240 cycles; reads of 0x00 and 0xEF return 0.
